alarm_ringer: RTL and testbench
===============================

# alarm_ringer

Alarm sequencing stage downstream of the clock/alarm-set datapath. It consumes the alarm-time-equals-clock-time match, the 1 Hz seconds tick and the debounced button pulses. It produces a gated square-wave buzzer drive plus status flags, with a timed ring window, a snooze countdown and a snooze limit. It replaces the raw match level currently routed to the alarm LED.

## Interface
Parameters:
- TONE_HALF, 50000: clk cycles per buzzer tone half-period (1 kHz at 100 MHz).
- RING_SEC, 60: seconds of ringing before auto-stop.
- SNOOZE_SEC, 300: seconds of snooze before re-ring.
- MAX_SNOOZE, 3: snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- sec_tick  in  1  one-cycle pulse once per second (seconds-counter carry).
- alarm_match  in  1  level; high while the alarm HH:MM equals the clock HH:MM.
- alarm_en  in  1  level; alarm armed (switch).
- snooze  in  1  one-cycle debounced button pulse.
- dismiss  in  1  one-cycle debounced button pulse.
- buzzer  out  1  tone drive, registered.
- ringing  out  1  high in RINGING, registered.
- snoozing  out  1  high in SNOOZE, registered.
- snooze_left  out  2  remaining snoozes, registered.

## Operation
- State machine has three states: IDLE, RINGING and SNOOZE.
- match_q is alarm_match registered. The trigger is match_rise = alarm_match & ~match_q.
- IDLE:
  - On alarm_en & match_rise: go to RINGING, ring_cnt=0, snooze_left=MAX_SNOOZE, cadence=1, tone counter=0, tone=1.
  - Using the edge means a dismissed alarm does not retrigger during the same matching minute.
- RINGING, priority order:
  - ~alarm_en or dismiss: go to IDLE.
  - snooze & snooze_left!=0: go to SNOOZE, snz_cnt=0, snooze_left decrements.
  - snooze with snooze_left==0: ignored.
  - sec_tick & ring_cnt==RING_SEC-1: go to IDLE (timeout).
  - sec_tick otherwise: ring_cnt increments and cadence toggles.
- SNOOZE, priority order:
  - ~alarm_en or dismiss: go to IDLE.
  - sec_tick & snz_cnt==SNOOZE_SEC-1: go to RINGING with ring_cnt=0, cadence=1, tone restarted.
  - sec_tick otherwise: snz_cnt increments.
  - snooze is ignored in this state.
- Tone generator:
  - Runs only in RINGING.
  - Counter 0..TONE_HALF-1. At the terminal count it wraps to 0 and tone toggles.
- Output registers:
  - buzzer = tone & cadence while the next state is RINGING, otherwise 0.
  - ringing and snoozing decode the next state.
  - snooze_left holds its value in IDLE until the next trigger.
- Counter widths: ring_cnt is clog2(RING_SEC), snz_cnt is clog2(SNOOZE_SEC), the tone counter is clog2(TONE_HALF).
- Counters never exceed terminal-1; the wrap is explicit, not a natural overflow.
- match_rise while in RINGING or SNOOZE has no effect.

## Timing
- Reset: state=IDLE, match_q=0, every counter 0, tone=0, cadence=0. Outputs: buzzer=0, ringing=0, snoozing=0, snooze_left=0.
- Reset asserted mid-ring or mid-snooze returns everything to reset values on the next edge.
- Latency from any state-changing input to ringing/snoozing: 1 clk.
  - A match edge sampled at cycle N gives ringing=1 after edge N+1. This depends on alarm_match staying high at N; match_q is updated in the same cycle.
- On entry to RINGING, buzzer=1 from the first RINGING cycle. It toggles every TONE_HALF clks during audible seconds and is 0 during silent (cadence=0) seconds.
- Timeout: exactly RING_SEC sec_tick pulses after entry, ringing falls 1 clk after the last tick.
- Snooze length: exactly SNOOZE_SEC sec_tick pulses.
- Simultaneous events in a single cycle:
  - dismiss+snooze: dismiss wins.
  - dismiss+sec_tick at timeout: IDLE either way.
  - snooze+sec_tick at ring timeout: snooze wins if snooze_left!=0, else timeout.

## Test plan
Benches use TONE_HALF=4, RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2, with sec_tick every 20 clks.
- Reset with alarm_match=1 held, alarm_en=1 -> no ringing (no edge after reset? match_q=0, so first cycle out of reset rings; check ringing=1 at cycle 2, snooze_left=2).
- Trigger, then no buttons -> buzzer toggles every 4 clks for the first second, silent for the second, audible for the third. ringing falls after the 5th sec_tick.
- Trigger, then snooze -> snoozing=1, snooze_left=1. After 3 ticks ringing=1 again. Snooze again -> snooze_left=0. Third snooze while ringing -> ignored, ringing stays 1.
- Dismiss during RINGING with alarm_match still high -> IDLE, no re-ring while match stays high. Drop match, then raise it -> rings again.
- dismiss and snooze in the same cycle -> IDLE, snoozing=0. alarm_en deasserted mid-snooze -> IDLE next clk.
- Assert rst while ringing at buzzer=1 -> all outputs 0 on the next edge, snooze_left=0.

Source files
------------

// File: rtl/alarm_ringer.sv
// Alarm sequencer: turns the alarm-time match edge into a timed, cadenced buzzer
// with snooze countdown and a per-event snooze limit.
module alarm_ringer #(
    parameter int TONE_HALF  = 50000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       alarm_match,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_left
);

    localparam int TONE_W = (TONE_HALF  > 1) ? $clog2(TONE_HALF)  : 1;
    localparam int RING_W = (RING_SEC   > 1) ? $clog2(RING_SEC)   : 1;
    localparam int SNZ_W  = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_match_q;
    logic [RING_W-1:0]   r_ring_cnt;
    logic [SNZ_W-1:0]    r_snz_cnt;
    logic [TONE_W-1:0]   r_tone_cnt;
    logic                r_tone;
    logic                r_cadence;
    logic [1:0]          r_snooze_left;
    logic                r_buzzer;
    logic                r_ringing;
    logic                r_snoozing;

    state_t              w_state_next;
    logic                w_match_rise;
    logic [RING_W-1:0]   w_ring_cnt_next;
    logic [SNZ_W-1:0]    w_snz_cnt_next;
    logic [TONE_W-1:0]   w_tone_cnt_next;
    logic                w_tone_next;
    logic                w_cadence_next;
    logic                w_tone_restart;
    logic [1:0]          w_snooze_left_next;
    logic                w_buzzer_next;
    logic                w_ringing_next;
    logic                w_snoozing_next;

    // Edge, not level: a dismissed alarm stays quiet for the rest of the matching minute.
    assign w_match_rise = alarm_match & ~r_match_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_match_q     <= 1'b0;
            r_ring_cnt    <= '0;
            r_snz_cnt     <= '0;
            r_tone_cnt    <= '0;
            r_tone        <= 1'b0;
            r_cadence     <= 1'b0;
            r_snooze_left <= 2'd0;
            r_buzzer      <= 1'b0;
            r_ringing     <= 1'b0;
            r_snoozing    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_match_q     <= alarm_match;
            r_ring_cnt    <= w_ring_cnt_next;
            r_snz_cnt     <= w_snz_cnt_next;
            r_tone_cnt    <= w_tone_cnt_next;
            r_tone        <= w_tone_next;
            r_cadence     <= w_cadence_next;
            r_snooze_left <= w_snooze_left_next;
            r_buzzer      <= w_buzzer_next;
            r_ringing     <= w_ringing_next;
            r_snoozing    <= w_snoozing_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_ring_cnt_next    = r_ring_cnt;
        w_snz_cnt_next     = r_snz_cnt;
        w_snooze_left_next = r_snooze_left;
        w_cadence_next     = r_cadence;
        w_tone_restart     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (alarm_en && w_match_rise) begin
                    w_state_next       = ST_RINGING;
                    w_ring_cnt_next    = '0;
                    w_snooze_left_next = 2'(MAX_SNOOZE);
                    w_cadence_next     = 1'b1;
                    w_tone_restart     = 1'b1;
                end
            end
            ST_RINGING: begin
                if (!alarm_en || dismiss) begin
                    w_state_next = ST_IDLE;
                end else if (snooze && (r_snooze_left != 2'd0)) begin
                    w_state_next       = ST_SNOOZE;
                    w_snz_cnt_next     = '0;
                    w_snooze_left_next = r_snooze_left - 2'd1;
                end else if (sec_tick) begin
                    if (r_ring_cnt == RING_W'(RING_SEC - 1)) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ring_cnt_next = r_ring_cnt + RING_W'(1);
                        w_cadence_next  = ~r_cadence;
                    end
                end
            end
            ST_SNOOZE: begin
                if (!alarm_en || dismiss) begin
                    w_state_next = ST_IDLE;
                end else if (sec_tick) begin
                    if (r_snz_cnt == SNZ_W'(SNOOZE_SEC - 1)) begin
                        w_state_next    = ST_RINGING;
                        w_ring_cnt_next = '0;
                        w_cadence_next  = 1'b1;
                        w_tone_restart  = 1'b1;
                    end else begin
                        w_snz_cnt_next = r_snz_cnt + SNZ_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Tone half-period counter free-runs only while ringing; outputs decode the next state.
    always_comb begin
        w_tone_cnt_next = r_tone_cnt;
        w_tone_next     = r_tone;
        if (w_tone_restart) begin
            w_tone_cnt_next = '0;
            w_tone_next     = 1'b1;
        end else if (r_state == ST_RINGING) begin
            if (r_tone_cnt == TONE_W'(TONE_HALF - 1)) begin
                w_tone_cnt_next = '0;
                w_tone_next     = ~r_tone;
            end else begin
                w_tone_cnt_next = r_tone_cnt + TONE_W'(1);
            end
        end
        w_ringing_next  = (w_state_next == ST_RINGING);
        w_snoozing_next = (w_state_next == ST_SNOOZE);
        w_buzzer_next   = w_ringing_next & w_tone_next & w_cadence_next;
    end

    assign buzzer      = r_buzzer;
    assign ringing     = r_ringing;
    assign snoozing    = r_snoozing;
    assign snooze_left = r_snooze_left;

endmodule

// File: tb/tb_alarm_ringer.sv
module tb_alarm_ringer;

    logic       clk;
    logic       rst;
    logic       sec_tick;
    logic       alarm_match;
    logic       alarm_en;
    logic       snooze;
    logic       dismiss;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_left;

    alarm_ringer #(
        .TONE_HALF (4),
        .RING_SEC  (5),
        .SNOOZE_SEC(3),
        .MAX_SNOOZE(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .alarm_match(alarm_match),
        .alarm_en   (alarm_en),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .buzzer     (buzzer),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .snooze_left(snooze_left)
    );

    typedef struct {
        int         cyc;
        logic       b;
        logic       r;
        logic       s;
        logic [1:0] l;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_check++;
            if (mon_e.cyc != cyc ||
                {buzzer, ringing, snoozing, snooze_left} !== {mon_e.b, mon_e.r, mon_e.s, mon_e.l}) begin
                n_fail++;
                $display("FAIL %s cyc=%0d(due %0d) got buz=%b ring=%b snz=%b left=%0d required buz=%b ring=%b snz=%b left=%0d",
                         mon_e.name, cyc, mon_e.cyc, buzzer, ringing, snoozing, snooze_left,
                         mon_e.b, mon_e.r, mon_e.s, mon_e.l);
            end else begin
                $display("check %s cyc=%0d buz=%b ring=%b snz=%b left=%0d ok",
                         mon_e.name, cyc, buzzer, ringing, snoozing, snooze_left);
            end
        end
    end

    task automatic expect_at(input int c, input string name, input logic b, input logic r,
                             input logic s, input logic [1:0] l);
        exp_t e;
        e.cyc = c; e.b = b; e.r = r; e.s = s; e.l = l; e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_now(input string name, input logic b, input logic r,
                              input logic s, input logic [1:0] l);
        expect_at(cyc, name, b, r, s, l);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sec_tick = 1'b0;
        snooze   = 1'b0;
        dismiss  = 1'b0;
    endtask

    task automatic tick_after(input int n);
        repeat (n) step();
        sec_tick = 1'b1;
        step();
    endtask

    task automatic trigger();
        alarm_match = 1'b0;
        step();
        alarm_match = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst = 1'b1; sec_tick = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        alarm_match = 1'b1; alarm_en = 1'b1;
        repeat (3) step();
        expect_now("reset_state", 1'b0, 1'b0, 1'b0, 2'd0);
        n_check++;
        if ({buzzer, ringing, snoozing, snooze_left} !== 5'b0_0_0_00) begin
            n_fail++;
            $display("FAIL direct_reset_state cyc=%0d got buz=%b ring=%b snz=%b left=%0d",
                     cyc, buzzer, ringing, snoozing, snooze_left);
        end else begin
            $display("check direct_reset_state cyc=%0d ok", cyc);
        end

        rst = 1'b0;
        e0  = cyc + 1;
        for (int c = 0; c < 100; c++) begin
            expect_at(e0 + c, "ring_cadence", ((c / 20) % 2 == 0) && ((c / 4) % 2 == 0),
                      1'b1, 1'b0, 2'd2);
        end
        expect_at(e0 + 100, "ring_timeout", 1'b0, 1'b0, 1'b0, 2'd2);
        step();
        for (int j = 0; j < 5; j++) tick_after(19);

        repeat (5) step();
        expect_now("no_retrig_level", 1'b0, 1'b0, 1'b0, 2'd2);

        trigger();
        expect_now("trig_snz", 1'b1, 1'b1, 1'b0, 2'd2);
        step(); step();
        expect_now("tone_hi_cnt2", 1'b1, 1'b1, 1'b0, 2'd2);
        snooze = 1'b1; step();
        expect_now("snooze_1", 1'b0, 1'b0, 1'b1, 2'd1);
        n_check++;
        if ({buzzer, ringing, snoozing, snooze_left} !== 5'b0_0_1_01) begin
            n_fail++;
            $display("FAIL direct_snooze_1 cyc=%0d got buz=%b ring=%b snz=%b left=%0d",
                     cyc, buzzer, ringing, snoozing, snooze_left);
        end else begin
            $display("check direct_snooze_1 cyc=%0d ok", cyc);
        end
        tick_after(19); tick_after(19);
        expect_now("snz_two_ticks", 1'b0, 1'b0, 1'b1, 2'd1);
        snooze = 1'b1; step();
        expect_now("snooze_in_snz_ign", 1'b0, 1'b0, 1'b1, 2'd1);
        tick_after(18);
        expect_now("rering_1", 1'b1, 1'b1, 1'b0, 2'd1);
        snooze = 1'b1; step();
        expect_now("snooze_2", 1'b0, 1'b0, 1'b1, 2'd0);
        tick_after(19); tick_after(19); tick_after(19);
        expect_now("rering_2", 1'b1, 1'b1, 1'b0, 2'd0);
        snooze = 1'b1; step();
        expect_now("snooze_3_ignored", 1'b1, 1'b1, 1'b0, 2'd0);
        for (int j = 0; j < 4; j++) tick_after(19);
        expect_now("ring_cnt_4", 1'b1, 1'b1, 1'b0, 2'd0);
        snooze = 1'b1; sec_tick = 1'b1; step();
        expect_now("snz_tick_timeout", 1'b0, 1'b0, 1'b0, 2'd0);

        trigger();
        expect_now("trig_dis", 1'b1, 1'b1, 1'b0, 2'd2);
        dismiss = 1'b1; step();
        expect_now("dismiss", 1'b0, 1'b0, 1'b0, 2'd2);
        n_check++;
        if ({buzzer, ringing, snoozing, snooze_left} !== 5'b0_0_0_10) begin
            n_fail++;
            $display("FAIL direct_dismiss cyc=%0d got buz=%b ring=%b snz=%b left=%0d",
                     cyc, buzzer, ringing, snoozing, snooze_left);
        end else begin
            $display("check direct_dismiss cyc=%0d ok", cyc);
        end
        repeat (10) step();
        expect_now("no_rering_match_hi", 1'b0, 1'b0, 1'b0, 2'd2);
        trigger();
        expect_now("rering_new_edge", 1'b1, 1'b1, 1'b0, 2'd2);
        dismiss = 1'b1; snooze = 1'b1; step();
        expect_now("dismiss_and_snooze", 1'b0, 1'b0, 1'b0, 2'd2);

        trigger();
        snooze = 1'b1; step();
        expect_now("snooze_en_test", 1'b0, 1'b0, 1'b1, 2'd1);
        tick_after(5);
        alarm_en = 1'b0; step();
        expect_now("en_off_in_snz", 1'b0, 1'b0, 1'b0, 2'd1);
        trigger();
        expect_now("en_off_no_trig", 1'b0, 1'b0, 1'b0, 2'd1);
        alarm_en = 1'b1; repeat (3) step();
        expect_now("en_on_no_edge", 1'b0, 1'b0, 1'b0, 2'd1);
        trigger();
        expect_now("trig_en_ring", 1'b1, 1'b1, 1'b0, 2'd2);
        alarm_en = 1'b0; step();
        expect_now("en_off_in_ring", 1'b0, 1'b0, 1'b0, 2'd2);
        alarm_en = 1'b1;

        trigger();
        expect_now("trig_rst", 1'b1, 1'b1, 1'b0, 2'd2);
        rst = 1'b1; step();
        expect_now("rst_mid_ring", 1'b0, 1'b0, 1'b0, 2'd0);
        n_check++;
        if ({buzzer, ringing, snoozing, snooze_left} !== 5'b0_0_0_00) begin
            n_fail++;
            $display("FAIL direct_rst_mid_ring cyc=%0d got buz=%b ring=%b snz=%b left=%0d",
                     cyc, buzzer, ringing, snoozing, snooze_left);
        end else begin
            $display("check direct_rst_mid_ring cyc=%0d ok", cyc);
        end
        alarm_match = 1'b0; step();
        rst = 1'b0; step();
        expect_now("post_rst_idle", 1'b0, 1'b0, 1'b0, 2'd0);
        trigger();
        expect_now("trig_after_rst", 1'b1, 1'b1, 1'b0, 2'd2);

        repeat (3) step();
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_check++;
            n_fail++;
            $display("FAIL %s never compared, due cyc=%0d now cyc=%0d", mon_e.name, mon_e.cyc, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
